// File: rtl/input_conditioner_pkg.sv
// Shared constants for the entry/exit front-end: clock rate, default debounce
// window and the idle (released) level of each raw input.
package input_conditioner_pkg;

  localparam int CLK_FREQ_HZ  = 50_000_000;
  localparam int DEBOUNCE_1MS = CLK_FREQ_HZ / 1000;

  localparam logic [1:0] SW_IDLE  = 2'b00;
  localparam logic       KEY_IDLE = 1'b1;

endpackage

// File: rtl/input_conditioner_if.sv
// Raw switch/sensor pins in, clean levels and edge pulses out.
// The slave side is the conditioner; the master side is whoever drives the pins.
interface input_conditioner_if;

  logic [1:0] sw;
  logic       key;
  logic [1:0] sw_clean;
  logic       key_clean;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;
  logic       key_press;
  logic       key_release;
  logic       sw_change;

  modport master (
    output sw, key,
    input  sw_clean, key_clean, sw_rise, sw_fall,
    input  key_press, key_release, sw_change
  );

  modport slave (
    input  sw, key,
    output sw_clean, key_clean, sw_rise, sw_fall,
    output key_press, key_release, sw_change
  );

endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One synchronise-and-debounce lane: 2-flop synchroniser, stability counter,
// clean level register and registered rise/fall pulses.
module debounce_channel #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_W           = 16,
  parameter logic IDLE_VAL        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE_VAL;
      sync2 <= IDLE_VAL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The counter only runs while the synchronised level disagrees with clean;
  // any agreement restarts the window, so short glitches never commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      clean <= IDLE_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        clean <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Front-end for the entry/exit FSM: three independent debounce lanes (SW[1],
// SW[0], KEY) plus the KEY pulse naming and the combined switch-change pulse.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
  parameter int CNT_W           = 16
) (
  input logic                clk,
  input logic                rst_n,
  input_conditioner_if.slave bus
);

  logic [1:0] sw_clean;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;
  logic       key_clean;
  logic       key_rise;
  logic       key_fall;

  for (genvar i = 0; i < 2; i++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .IDLE_VAL        (SW_IDLE[i])
    ) u_sw (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.sw[i]),
      .clean (sw_clean[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i])
    );
  end

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .IDLE_VAL        (KEY_IDLE)
  ) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.key),
    .clean (key_clean),
    .rise  (key_rise),
    .fall  (key_fall)
  );

  // KEY is active-low, so a press is the falling edge of the clean level.
  assign bus.sw_clean    = sw_clean;
  assign bus.sw_rise     = sw_rise;
  assign bus.sw_fall     = sw_fall;
  assign bus.key_clean   = key_clean;
  assign bus.key_press   = key_fall;
  assign bus.key_release = key_rise;
  assign bus.sw_change   = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Scenario bench for input_conditioner with a 4-cycle debounce window; every
// cycle's expected output vector is queued up front and popped after the edge.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         edgeNo;
    logic [9:0] v;
  } exp_t;

  exp_t sbQ[$];

  // {sw_clean, key_clean, sw_rise, sw_fall, key_press, key_release, sw_change}
  localparam logic [9:0] IDLE_OBS = 10'b00_1_00_00_0_0_0;

  function automatic logic [9:0] mk(logic [1:0] c, logic k, logic [1:0] r,
                                    logic [1:0] f, logic p, logic rl, logic ch);
    return {c, k, r, f, p, rl, ch};
  endfunction

  function automatic logic [9:0] observed();
    return {bus.sw_clean, bus.key_clean, bus.sw_rise, bus.sw_fall,
            bus.key_press, bus.key_release, bus.sw_change};
  endfunction

  task automatic pushExp(string tag, int n, logic [9:0] v);
    exp_t e;
    e.tag = tag;
    e.edgeNo = n;
    e.v = v;
    sbQ.push_back(e);
  endtask

  task automatic resetDut();
    bus.sw = 2'b00;
    bus.key = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [9:0] got;
    for (int n = 1; n <= 7; n++) pushExp("reset", n, IDLE_OBS);
    rst_n = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      bus.sw  = (n == 3 || n == 4) ? 2'b11 : 2'b00;
      bus.key = (n == 3 || n == 4) ? 1'b0 : 1'b1;
      if (n == 5) rst_n = 1'b1;
      @(posedge clk);
      #1;
      e = sbQ.pop_front();
      got = observed();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, e.edgeNo, got, e.v);
      end
    end
  endtask

  task automatic test_sw1_rise();
    exp_t e;
    logic [9:0] got;
    resetDut();
    for (int n = 1; n <= 8; n++)
      pushExp("sw1_rise", n, (n == 6) ? mk(2'b10, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1) :
                             (n > 6)  ? mk(2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0) :
                                        IDLE_OBS);
    for (int n = 1; n <= 8; n++) begin
      bus.sw = 2'b10;
      bus.key = 1'b1;
      @(posedge clk);
      #1;
      e = sbQ.pop_front();
      got = observed();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, e.edgeNo, got, e.v);
      end
    end
  endtask

  task automatic test_key_glitch_press();
    exp_t e;
    logic [9:0] got;
    resetDut();
    for (int n = 1; n <= 24; n++)
      pushExp("key_glitch_press", n,
              (n == 14)             ? mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0) :
              (n > 14 && n < 22)    ? mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0) :
              (n == 22)             ? mk(2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0) :
                                      IDLE_OBS);
    for (int n = 1; n <= 24; n++) begin
      bus.sw = 2'b00;
      bus.key = (n <= 3 || (n >= 9 && n <= 16)) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      e = sbQ.pop_front();
      got = observed();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, e.edgeNo, got, e.v);
      end
    end
  endtask

  task automatic test_sw_both();
    exp_t e;
    logic [9:0] got;
    resetDut();
    for (int n = 1; n <= 16; n++)
      pushExp("sw_both", n,
              (n == 6)           ? mk(2'b11, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1) :
              (n > 6 && n < 14)  ? mk(2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0) :
              (n == 14)          ? mk(2'b00, 1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1) :
                                   IDLE_OBS);
    for (int n = 1; n <= 16; n++) begin
      bus.sw = (n <= 8) ? 2'b11 : 2'b00;
      bus.key = 1'b1;
      @(posedge clk);
      #1;
      e = sbQ.pop_front();
      got = observed();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, e.edgeNo, got, e.v);
      end
    end
  endtask

  task automatic test_sw0_bounce();
    exp_t e;
    logic [9:0] got;
    resetDut();
    for (int n = 1; n <= 12; n++)
      pushExp("sw0_bounce", n,
              (n == 10) ? mk(2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1) :
              (n > 10)  ? mk(2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0) :
                          IDLE_OBS);
    for (int n = 1; n <= 12; n++) begin
      bus.sw = (n <= 5) ? {1'b0, n[0]} : 2'b01;
      bus.key = 1'b1;
      @(posedge clk);
      #1;
      e = sbQ.pop_front();
      got = observed();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, e.edgeNo, got, e.v);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    exp_t e;
    logic [9:0] got;
    resetDut();
    for (int n = 1; n <= 8; n++)
      pushExp("midrst_setup", n,
              (n == 6) ? mk(2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1) :
              (n > 6)  ? mk(2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0) :
                         IDLE_OBS);
    for (int n = 1; n <= 4; n++)
      pushExp("midrst_count", n, mk(2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    for (int n = 0; n <= 2; n++) pushExp("midrst_held", n, IDLE_OBS);
    for (int n = 1; n <= 8; n++)
      pushExp("midrst_after", n,
              (n == 6) ? mk(2'b11, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1) :
              (n > 6)  ? mk(2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0) :
                         IDLE_OBS);
    for (int n = 1; n <= 12; n++) begin
      bus.sw = (n <= 8) ? 2'b01 : 2'b11;
      bus.key = 1'b1;
      @(posedge clk);
      #1;
      e = sbQ.pop_front();
      got = observed();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, e.edgeNo, got, e.v);
      end
    end
    #3 rst_n = 1'b0;
    for (int n = 0; n <= 2; n++) begin
      if (n == 0) #1;
      else begin
        @(posedge clk);
        #1;
      end
      e = sbQ.pop_front();
      got = observed();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s step %0d: got %b expected %b", e.tag, e.edgeNo, got, e.v);
      end
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      e = sbQ.pop_front();
      got = observed();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, e.edgeNo, got, e.v);
      end
    end
  endtask

  initial begin
    bus.sw = 2'b00;
    bus.key = 1'b1;
    test_reset();
    test_sw1_rise();
    test_key_glitch_press();
    test_sw_both();
    test_sw0_bounce();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
